// File: rtl/pc_seq.sv
// Fetch PC sequencer with a direct-mapped branch target buffer of 2-bit counters.
// It redirects fetch and issues a one-cycle flush when a resolved branch was mispredicted.
module pc_seq #(
   parameter logic [31:0] RESET_PC  = 32'h8000_0000,
   parameter int unsigned BTB_IDX_W = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_pred_npc,
   input  logic        ex_valid,
   input  logic        ex_is_branch,
   input  logic        ex_taken,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic [31:0] ex_pred_npc,
   output logic        flush,
   output logic [15:0] mispred_cnt
);

   localparam int unsigned DEPTH = 2 ** BTB_IDX_W;
   localparam int unsigned TAG_W = 32 - BTB_IDX_W - 2;

   typedef enum logic {RUN, FLUSH} state_e;

   state_e                 state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [31:0]            pred_q, pred_d;
   logic                   fv_q, fv_d;
   logic                   flush_q, flush_d;
   logic [15:0]            cnt_q, cnt_d;
   logic [DEPTH-1:0]       valid_q, valid_d;

   logic [TAG_W-1:0]       tag_q [DEPTH];
   logic [31:0]            tgt_q [DEPTH];
   logic [1:0]             ctr_q [DEPTH];

   logic [31:0]            actual_npc;
   logic                   mispred;
   logic                   pc_load;
   logic [BTB_IDX_W-1:0]   p_idx, u_idx;
   logic [TAG_W-1:0]       p_tag, u_tag;
   logic                   p_taken, u_hit;
   logic                   alloc, bump;
   logic [1:0]             ctr_nxt;

   // Redirect, prediction lookup for the next fetch address, and table update decode
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pred_d     = pred_q;
      cnt_d      = cnt_q;
      valid_d    = valid_q;
      alloc      = 1'b0;
      bump       = 1'b0;
      ctr_nxt    = 2'b00;

      actual_npc = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
      mispred    = (state_q == RUN) && ex_valid && (actual_npc != ex_pred_npc);
      pc_load    = 1'b0;

      if (mispred) begin
         pc_d    = actual_npc;
         state_d = FLUSH;
         cnt_d   = cnt_q + 16'd1;
         pc_load = 1'b1;
      end else begin
         state_d = RUN;
         if (fv_q && fetch_ready) begin
            pc_d    = pred_q;
            pc_load = 1'b1;
         end
      end

      // Prediction is captured with the address so it stays stable under stall
      p_idx   = pc_d[BTB_IDX_W+1:2];
      p_tag   = pc_d[31:BTB_IDX_W+2];
      p_taken = valid_q[p_idx] && (tag_q[p_idx] == p_tag) && ctr_q[p_idx][1];
      if (pc_load) pred_d = p_taken ? tgt_q[p_idx] : pc_d + 32'd4;

      u_idx = ex_pc[BTB_IDX_W+1:2];
      u_tag = ex_pc[31:BTB_IDX_W+2];
      u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
      if ((state_q == RUN) && ex_valid && ex_is_branch) begin
         if (u_hit) begin
            bump    = 1'b1;
            ctr_nxt = ctr_q[u_idx];
            if (ex_taken && ctr_q[u_idx] != 2'b11) ctr_nxt = ctr_q[u_idx] + 2'b01;
            else if (!ex_taken && ctr_q[u_idx] != 2'b00) ctr_nxt = ctr_q[u_idx] - 2'b01;
         end else if (ex_taken) begin
            alloc          = 1'b1;
            valid_d[u_idx] = 1'b1;
         end
      end

      fv_d    = (state_d == RUN);
      flush_d = (state_d == FLUSH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         pred_q  <= RESET_PC + 32'd4;
         fv_q    <= 1'b0;
         flush_q <= 1'b0;
         cnt_q   <= 16'd0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pred_q  <= pred_d;
         fv_q    <= fv_d;
         flush_q <= flush_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   // Entry payload needs no reset; valid bits gate every use
   always_ff @(posedge clk) begin
      if (alloc) begin
         tag_q[u_idx] <= u_tag;
         tgt_q[u_idx] <= ex_target;
         ctr_q[u_idx] <= 2'b10;
      end else if (bump) begin
         ctr_q[u_idx] <= ctr_nxt;
      end
   end

   assign fetch_valid    = fv_q;
   assign fetch_pc       = pc_q;
   assign fetch_pred_npc = pred_q;
   assign flush          = flush_q;
   assign mispred_cnt    = cnt_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: sequencing, redirect/flush, counter training and reset abort.
module tb_pc_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_pred_npc;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_taken;
   logic [31:0] ex_pc;
   logic [31:0] ex_target;
   logic [31:0] ex_pred_npc;
   logic        flush;
   logic [15:0] mispred_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   pc_seq dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_valid    (fetch_valid),
      .fetch_ready    (fetch_ready),
      .fetch_pc       (fetch_pc),
      .fetch_pred_npc (fetch_pred_npc),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_taken       (ex_taken),
      .ex_pc          (ex_pc),
      .ex_target      (ex_target),
      .ex_pred_npc    (ex_pred_npc),
      .flush          (flush),
      .mispred_cnt    (mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic ex_drive(input logic v, input logic br, input logic tk,
                           input logic [31:0] pc, input logic [31:0] tgt, input logic [31:0] pn);
      ex_valid     = v;
      ex_is_branch = br;
      ex_taken     = tk;
      ex_pc        = pc;
      ex_target    = tgt;
      ex_pred_npc  = pn;
   endtask

   logic [1:0] exp_up [4];
   logic [1:0] exp_dn [4];

   initial begin
      exp_up = '{2'b10, 2'b11, 2'b11, 2'b11};
      exp_dn = '{2'b10, 2'b01, 2'b00, 2'b00};
      rst_n       = 1'b0;
      fetch_ready = 1'b0;
      ex_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(fetch_valid), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_pc", fetch_pc, 32'h8000_0000);
      chk("rst_cnt", 32'(mispred_cnt), 32'd0);
      rst_n       = 1'b1;
      fetch_ready = 1'b1;

      // Sequential fetch from an empty table
      @(negedge clk);
      chk("seq0_valid", 32'(fetch_valid), 32'd1);
      chk("seq0_pc", fetch_pc, 32'h8000_0000);
      chk("seq0_pred", fetch_pred_npc, 32'h8000_0004);
      @(negedge clk);
      chk("seq1_pc", fetch_pc, 32'h8000_0004);
      @(negedge clk);
      chk("seq2_pc", fetch_pc, 32'h8000_0008);
      chk("seq2_flush", 32'(flush), 32'd0);

      // Taken miss with fetch handshake in the same cycle: mispredict wins, allocate
      ex_drive(1'b1, 1'b1, 1'b1, 32'h8000_0010, 32'h8000_0100, 32'h8000_0014);
      @(negedge clk);
      chk("mp1_flush", 32'(flush), 32'd1);
      chk("mp1_valid", 32'(fetch_valid), 32'd0);
      chk("mp1_pc", fetch_pc, 32'h8000_0100);
      chk("mp1_cnt", 32'(mispred_cnt), 32'd1);
      chk("mp1_ctr", 32'(dut.ctr_q[4]), 32'd2);
      chk("mp1_vld", 32'(dut.valid_q[4]), 32'd1);

      // Input during FLUSH must be ignored
      ex_drive(1'b1, 1'b1, 1'b1, 32'h8000_0040, 32'h8000_0300, 32'h0);
      fetch_ready = 1'b0;
      @(negedge clk);
      chk("fl_flush", 32'(flush), 32'd0);
      chk("fl_valid", 32'(fetch_valid), 32'd1);
      chk("fl_pc", fetch_pc, 32'h8000_0100);
      chk("fl_cnt", 32'(mispred_cnt), 32'd1);
      chk("fl_noalloc", 32'(dut.valid_q[0]), 32'd0);
      chk("fl_pred", fetch_pred_npc, 32'h8000_0104);
      ex_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

      // Stall holds address and prediction
      @(negedge clk);
      chk("hold_pc", fetch_pc, 32'h8000_0100);
      chk("hold_pred", fetch_pred_npc, 32'h8000_0104);

      // Non-branch redirect to 8000_0010, which now predicts taken
      ex_drive(1'b1, 1'b0, 1'b0, 32'h8000_000C, 32'h0, 32'h0);
      @(negedge clk);
      chk("nb_pc", fetch_pc, 32'h8000_0010);
      chk("nb_pred", fetch_pred_npc, 32'h8000_0100);
      chk("nb_cnt", 32'(mispred_cnt), 32'd2);
      chk("nb_flush", 32'(flush), 32'd1);
      chk("nb_notable", 32'(dut.valid_q[3]), 32'd0);
      ex_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);

      // Not-taken resolve of the predicted-taken branch
      ex_drive(1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h8000_0100, 32'h8000_0100);
      @(negedge clk);
      chk("nt_ctr", 32'(dut.ctr_q[4]), 32'd1);
      chk("nt_pc", fetch_pc, 32'h8000_0014);
      chk("nt_cnt", 32'(mispred_cnt), 32'd3);
      chk("nt_pred", fetch_pred_npc, 32'h8000_0018);
      ex_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);

      // Saturation up then down, all correctly predicted
      ex_drive(1'b1, 1'b1, 1'b1, 32'h8000_0010, 32'h8000_0100, 32'h8000_0100);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("sat_up%0d", i), 32'(dut.ctr_q[4]), 32'(exp_up[i]));
      end
      chk("sat_up_cnt", 32'(mispred_cnt), 32'd3);
      ex_drive(1'b1, 1'b1, 1'b0, 32'h8000_0010, 32'h8000_0100, 32'h8000_0014);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("sat_dn%0d", i), 32'(dut.ctr_q[4]), 32'(exp_dn[i]));
      end
      chk("sat_dn_cnt", 32'(mispred_cnt), 32'd3);
      chk("sat_dn_flush", 32'(flush), 32'd0);

      // Not-taken miss leaves the table alone
      ex_drive(1'b1, 1'b1, 1'b0, 32'h8000_0020, 32'h8000_0400, 32'h8000_0024);
      @(negedge clk);
      chk("ntmiss_vld", 32'(dut.valid_q[0]), 32'd0);
      chk("ntmiss_cnt", 32'(mispred_cnt), 32'd3);

      // Address wrap at the top of the space
      ex_drive(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0);
      @(negedge clk);
      chk("wrap_pc", fetch_pc, 32'hFFFF_FFFC);
      chk("wrap_pred", fetch_pred_npc, 32'h0000_0000);
      chk("wrap_cnt", 32'(mispred_cnt), 32'd4);
      ex_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      fetch_ready = 1'b1;
      @(negedge clk);
      chk("wrap_run", 32'(flush), 32'd0);
      @(negedge clk);
      chk("wrap_pc0", fetch_pc, 32'h0000_0000);
      chk("wrap_pred0", fetch_pred_npc, 32'h0000_0004);

      // Reset in the middle of FLUSH
      fetch_ready = 1'b0;
      ex_drive(1'b1, 1'b1, 1'b1, 32'h8000_0008, 32'h8000_0200, 32'h8000_000C);
      @(negedge clk);
      chk("rf_flush", 32'(flush), 32'd1);
      chk("rf_pc", fetch_pc, 32'h8000_0200);
      chk("rf_cnt", 32'(mispred_cnt), 32'd5);
      chk("rf_vld", 32'(dut.valid_q[2]), 32'd1);
      ex_drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      chk("rf_rst_pc", fetch_pc, 32'h8000_0000);
      chk("rf_rst_flush", 32'(flush), 32'd0);
      chk("rf_rst_valid", 32'(fetch_valid), 32'd0);
      chk("rf_rst_cnt", 32'(mispred_cnt), 32'd0);
      chk("rf_rst_tbl", 32'(dut.valid_q), 32'd0);
      @(negedge clk);
      rst_n       = 1'b1;
      fetch_ready = 1'b1;
      @(negedge clk);
      chk("rr0_flush", 32'(flush), 32'd0);
      chk("rr0_pc", fetch_pc, 32'h8000_0000);
      @(negedge clk);
      chk("rr1_pc", fetch_pc, 32'h8000_0004);
      chk("rr1_pred", fetch_pred_npc, 32'h8000_0008);
      @(negedge clk);
      chk("rr2_pc", fetch_pc, 32'h8000_0008);
      chk("rr2_pred", fetch_pred_npc, 32'h8000_000C);
      chk("rr2_flush", 32'(flush), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
